// File: rtl/filt_seq_pkg.sv
// Shared types and defaults for the filter sample sequencer.
package filt_seq_pkg;

    localparam int DATA_SIZE_DEFAULT = 24;

    // Two-bit state; unused encodings recover to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1
    } state_t;

endpackage

// File: rtl/sample_rate_divider.sv
// Free-running sample-rate divider: one-cycle tick every DIV clocks.
module sample_rate_divider #(
    parameter int DIV = 1024
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] tick_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick_cnt == LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/filter_sample_sequencer.sv
// Paces held samples into an IIR filter on each divider tick, waits for filter_done
// (with timeout), and presents the result on a valid/ready port with sticky error flags.
module filter_sample_sequencer
    import filt_seq_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEFAULT,
    parameter int DIV       = 1024,
    parameter int TIMEOUT   = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 in_ready,
    output logic [DATA_SIZE-1:0] filt_data_in,
    output logic                 sample_trig,
    input  logic                 filter_done,
    input  logic [DATA_SIZE-1:0] filt_data_out,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data,
    input  logic                 out_ready,
    output logic                 underrun,
    output logic                 overrun,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    state_t               state;
    logic                 tick;
    logic                 hold_full;
    logic [DATA_SIZE-1:0] hold;
    logic [WW-1:0]        wait_cnt;
    logic                 hold_take;
    logic                 load;
    logic                 done_in_wait;
    logic                 timeout_hit;
    logic                 underrun_set;
    logic                 overrun_set;

    sample_rate_divider #(.DIV(DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // NOTE: in_ready looks through to this cycle's take so a full register can be refilled without a bubble.
    assign hold_take    = (state == IDLE) && tick && hold_full;
    assign in_ready     = !hold_full || hold_take;
    assign load         = in_valid && in_ready;
    assign done_in_wait = (state == WAIT) && filter_done;
    assign timeout_hit  = (state == WAIT) && !filter_done && (wait_cnt == WAIT_LAST);
    assign underrun_set = (state == IDLE) && tick && !hold_full;
    assign overrun_set  = (done_in_wait && out_valid && !out_ready) || ((state == WAIT) && tick);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (load) begin
            hold      <= in_data;
            hold_full <= 1'b1;
        end else if (hold_take) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            sample_trig  <= 1'b0;
            filt_data_in <= '0;
        end else begin
            sample_trig <= 1'b0;
            case (state)
                IDLE: begin
                    if (hold_take) begin
                        filt_data_in <= hold;
                        sample_trig  <= 1'b1;
                        wait_cnt     <= '0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + WW'(1);
                    if (filter_done || timeout_hit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A capture in the same cycle as a handshake replaces the accepted word and keeps valid high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (done_in_wait) begin
            out_valid <= 1'b1;
            out_data  <= filt_data_out;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun    <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else if (err_clr) begin
            underrun    <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            underrun    <= underrun | underrun_set;
            overrun     <= overrun | overrun_set;
            timeout_err <= timeout_err | timeout_hit;
        end
    end

endmodule

// File: tb/tb_filter_sample_sequencer.sv
// Bench for filter_sample_sequencer: behavioural filter model plus result scoreboard.
module tb_filter_sample_sequencer;

    localparam int DW      = 24;
    localparam int DIV     = 16;
    localparam int TIMEOUT = 12;
    localparam int LAT     = 10;
    localparam logic [DW-1:0] STRAY = 24'hDEAD00;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [DW-1:0] filt_data_in;
    logic          sample_trig;
    logic          filter_done;
    logic [DW-1:0] filt_data_out;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b1;
    logic          underrun;
    logic          overrun;
    logic          timeout_err;
    logic          err_clr = 1'b0;

    logic          model_en = 1'b1;
    logic          model_done = 1'b0;
    logic [DW-1:0] model_out = '0;
    logic [DW-1:0] model_x = '0;
    int            model_cnt = 0;
    logic          stray_done = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int trig_count = 0;
    int loads = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl[4];

    assign filter_done   = model_done | stray_done;
    assign filt_data_out = stray_done ? STRAY : model_out;

    filter_sample_sequencer #(.DATA_SIZE(DW), .DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .filt_data_in  (filt_data_in),
        .sample_trig   (sample_trig),
        .filter_done   (filter_done),
        .filt_data_out (filt_data_out),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .underrun      (underrun),
        .overrun       (overrun),
        .timeout_err   (timeout_err),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] filt_fn(input logic [DW-1:0] x);
        return x ^ 24'h5A5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_phase(input int p);
        int n = 0;
        while ((cyc % DIV) != p && n < 2 * DIV) begin
            step();
            n++;
        end
        check("phase_reached", cyc % DIV, p);
    endtask

    task automatic load(input logic [DW-1:0] v, input logic [DW-1:0] e, input bit push);
        int n = 0;
        while (!in_ready && n < 2 * DIV) begin
            step();
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_data  = v;
        if (push) exp_q.push_back(e);
        loads++;
        step();
        in_valid = 1'b0;
    endtask

    // Edges since the last reset release; a trigger is expected only at multiples of DIV.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Filter model: done LAT cycles after trig, checks the input stays put meanwhile.
    always @(negedge clk) begin
        model_done = 1'b0;
        if (!reset) begin
            model_cnt = 0;
        end else begin
            if (model_cnt > 0) begin
                check("filt_data_in_stable", filt_data_in, model_x);
                model_cnt--;
                if (model_cnt == 0) begin
                    model_done = 1'b1;
                    model_out  = filt_fn(model_x);
                end
            end
            if (sample_trig) begin
                trig_count++;
                check("trig_phase", ((cyc % DIV) == 0) && (cyc != 0), 1);
                if (model_en) begin
                    model_x   = filt_data_in;
                    model_cnt = LAT;
                end
            end
        end
    end

    // Scoreboard: pop on every downstream handshake.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_out", out_valid, 0);
            end else begin
                check("sb_out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{24'h123456, 24'h486E0C};
        tbl[1] = '{24'h800000, 24'hDA5A5A};
        tbl[2] = '{24'h7FFFFF, 24'h25A5A5};
        tbl[3] = '{24'h000001, 24'h5A5A5B};

        #2 reset = 1'b0;
        repeat (3) step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_trig", sample_trig, 0);
        check("rst_flags", {underrun, overrun, timeout_err}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_filt_in", filt_data_in, 0);
        reset = 1'b1;

        // Underrun: first tick with nothing held.
        goto_phase(15);
        check("underrun_pre", underrun, 0);
        step();
        check("underrun_set", underrun, 1);
        check("underrun_no_trig", sample_trig, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("underrun_clr", underrun, 0);

        // Normal pacing: one sample per period, results through the scoreboard.
        for (int i = 0; i < 4; i++) begin
            load(tbl[i].data, tbl[i].exp, 1'b1);
            goto_phase(1);
        end
        goto_phase(13);
        check("norm_flags", {underrun, overrun, timeout_err}, 0);
        check("norm_drained", exp_q.size(), 0);

        // Overrun: two results with out_ready low.
        out_ready = 1'b0;
        load(24'h0F0F0F, 24'h555555, 1'b0);
        goto_phase(1);
        load(24'hABCDEF, 24'hF197B5, 1'b1);
        goto_phase(12);
        check("ovr_first_valid", out_valid, 1);
        check("ovr_first_data", out_data, 24'h555555);
        check("ovr_not_yet", overrun, 0);
        step();
        goto_phase(12);
        check("ovr_set", overrun, 1);
        check("ovr_second_data", out_data, 24'hF197B5);
        check("ovr_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        check("ovr_single_valid", out_valid, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ovr_clr", overrun, 0);

        // Done and handshake in the same cycle.
        out_ready = 1'b0;
        load(24'h00FF00, 24'h5AA55A, 1'b1);
        goto_phase(1);
        load(24'hFFFFFF, 24'hA5A5A5, 1'b1);
        goto_phase(12);
        check("same_old_valid", out_valid, 1);
        goto_phase(10);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("same_new_valid", out_valid, 1);
        check("same_new_data", out_data, 24'hA5A5A5);
        check("same_no_overrun", overrun, 0);
        out_ready = 1'b1;
        step();
        check("same_drained", out_valid, 0);

        // Stray done while idle.
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        check("stray_valid", out_valid, 0);
        check("stray_data", out_data, 24'hA5A5A5);

        // Timeout: filter never answers.
        model_en = 1'b0;
        load(24'h246802, 24'h7E3258, 1'b0);
        goto_phase(TIMEOUT - 1);
        check("tmo_pre", timeout_err, 0);
        step();
        check("tmo_set", timeout_err, 1);
        check("tmo_no_out", out_valid, 0);
        model_en = 1'b1;
        load(24'h13579B, 24'h490DC1, 1'b1);
        step();
        goto_phase(13);
        check("tmo_sticky", timeout_err, 1);
        check("tmo_recover_drained", exp_q.size(), 0);

        // Reset in the middle of a wait.
        load(24'h111111, 24'h4B4B4B, 1'b0);
        goto_phase(4);
        check("mid_filt_in", filt_data_in, 24'h111111);
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_outs", {out_valid, sample_trig, underrun, overrun, timeout_err}, 0);
        check("mid_rst_filt_in", filt_data_in, 0);
        check("mid_rst_out_data", out_data, 0);
        repeat (3) step();
        reset = 1'b1;
        load(24'h7A5C3E, 24'h200664, 1'b1);
        goto_phase(15);
        check("post_rst_no_early_trig", sample_trig, 0);
        step();
        check("post_rst_first_trig", sample_trig, 1);
        step();
        goto_phase(13);

        check("end_drained", exp_q.size(), 0);
        check("end_trig_count", trig_count, loads);
        check("end_flags", {underrun, overrun, timeout_err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
